out_port_ctrl: RTL and testbench

Output-port controller for the Nibbler CPU. It takes nibbles written by the CPU's OUT instruction (the enableOut strobe plus data_bus) into a small FIFO. It drives them onto the external 4-bit port with a 4-phase valid/ack handshake, so slow peripherals do not lose writes. It sits between the instruction decoder/data bus and the chip-level output pins, and replaces the direct enable-and-latch path.

---
 rtl/out_port_pkg.sv | 14 +
 rtl/out_fifo.sv | 69 ++++++
 rtl/out_port_ctrl.sv | 133 +++++++++++++
 tb/tb_out_port_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/out_port_pkg.sv
// Shared types and widths for the Nibbler output-port controller.
package out_port_pkg;

   localparam int unsigned NIBBLE_W = 4;

   // Handshake FSM: IDLE loads the next nibble, VALID waits for ack (or gives up),
   // RELEASE waits for the peripheral to drop ack.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      VALID   = 2'd1,
      RELEASE = 2'd2
   } state_t;

endpackage

// File: rtl/out_fifo.sv
// Small nibble FIFO between the CPU OUT strobe and the port handshake.
// Ports:
//   clk, reset      - clock, asynchronous active-low reset
//   push, push_data - write request and nibble
//   pop             - remove the head entry
//   head            - current head entry (valid when not empty)
//   count           - number of stored entries (0..DEPTH)
//   full, empty     - combinational status from count
// A push while full is accepted only when a pop happens in the same cycle.
module out_fifo
   import out_port_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic [NIBBLE_W-1:0]   push_data,
   input  logic                  pop,
   output logic [NIBBLE_W-1:0]   head,
   output logic [$clog2(DEPTH):0] count,
   output logic                  full,
   output logic                  empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [NIBBLE_W-1:0] mem [DEPTH];
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic                do_push;
   logic                do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   // Storage has no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap modulo DEPTH (power of two).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/out_port_ctrl.sv
// Output-port controller: buffers CPU OUT nibbles and presents them on the
// external port with a 4-phase valid/ack handshake.
// Ports:
//   clk, reset        - clock, asynchronous active-low reset
//   enableOut         - CPU write strobe, data_bus sampled when high
//   data_bus          - CPU nibble
//   data_out          - external port data (registered, held between transfers)
//   port_valid        - handshake request (registered)
//   port_ack          - peripheral acknowledge (synchronous)
//   busy              - FIFO full (combinational)
//   fifo_level        - FIFO entry count
//   err_clr           - clears sticky error flags (a same-cycle set wins)
//   overflow_err      - sticky: a write was dropped because the FIFO was full
//   timeout_err       - sticky: a nibble was dropped waiting for ack
module out_port_ctrl
   import out_port_pkg::*;
#(
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned ACK_TIMEOUT = 15
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enableOut,
   input  logic [NIBBLE_W-1:0]    data_bus,
   output logic [NIBBLE_W-1:0]    data_out,
   output logic                   port_valid,
   input  logic                   port_ack,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] fifo_level,
   input  logic                   err_clr,
   output logic                   overflow_err,
   output logic                   timeout_err
);

   localparam int unsigned TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

   state_t              state;
   state_t              state_nxt;
   logic [TW-1:0]       timer;
   logic [TW-1:0]       timer_nxt;
   logic [NIBBLE_W-1:0] data_nxt;
   logic                valid_nxt;
   logic                ovf_nxt;
   logic                to_nxt;
   logic                pop;
   logic                ovf_ev;
   logic                to_ev;
   logic [NIBBLE_W-1:0] head;
   logic                empty;

   out_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (enableOut),
      .push_data (data_bus),
      .pop       (pop),
      .head      (head),
      .count     (fifo_level),
      .full      (busy),
      .empty     (empty)
   );

   // State and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         timer        <= '0;
         data_out     <= '0;
         port_valid   <= 1'b0;
         overflow_err <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         state        <= state_nxt;
         timer        <= timer_nxt;
         data_out     <= data_nxt;
         port_valid   <= valid_nxt;
         overflow_err <= ovf_nxt;
         timeout_err  <= to_nxt;
      end
   end

   // Next-state, handshake and error-flag logic.
   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      data_nxt  = data_out;
      valid_nxt = port_valid;
      pop       = 1'b0;
      to_ev     = 1'b0;

      case (state)
         IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               data_nxt  = head;
               timer_nxt = '0;
               valid_nxt = 1'b1;
               state_nxt = VALID;
            end
         end
         VALID: begin
            if (port_ack) begin
               valid_nxt = 1'b0;
               state_nxt = RELEASE;
            end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
               // data_out keeps the dropped nibble
               valid_nxt = 1'b0;
               to_ev     = 1'b1;
               state_nxt = IDLE;
            end else begin
               timer_nxt = timer + TW'(1);
            end
         end
         RELEASE: begin
            if (!port_ack) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            valid_nxt = 1'b0;
            state_nxt = IDLE;
         end
      endcase

      // A full FIFO still accepts a write when the head leaves the same cycle.
      ovf_ev  = enableOut && busy && !pop;
      ovf_nxt = ovf_ev || (overflow_err && !err_clr);
      to_nxt  = to_ev  || (timeout_err  && !err_clr);
   end

endmodule

// File: tb/tb_out_port_ctrl.sv
// Bench for out_port_ctrl: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_out_port_ctrl;

   localparam int DEPTH       = 4;
   localparam int ACK_TIMEOUT = 15;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       enableOut = 1'b0;
   logic [3:0] data_bus = 4'h0;
   logic [3:0] data_out;
   logic       port_valid;
   logic       port_ack;
   logic       busy;
   logic [2:0] fifo_level;
   logic       err_clr = 1'b0;
   logic       overflow_err;
   logic       timeout_err;

   logic       auto_ack = 1'b0;
   logic       ack_auto = 1'b0;
   logic       ack_man  = 1'b0;
   assign port_ack = auto_ack ? ack_auto : ack_man;

   int n_cmp = 0;
   int n_bad = 0;

   out_port_ctrl #(
      .DEPTH       (DEPTH),
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enableOut    (enableOut),
      .data_bus     (data_bus),
      .data_out     (data_out),
      .port_valid   (port_valid),
      .port_ack     (port_ack),
      .busy         (busy),
      .fifo_level   (fifo_level),
      .err_clr      (err_clr),
      .overflow_err (overflow_err),
      .timeout_err  (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Prompt peripheral: acks whenever it sees valid, drops ack when valid drops.
   always @(posedge clk) begin
      #1;
      ack_auto = port_valid;
   end

   // Reference model: a queue of pending nibbles and a description of the port.
   logic [3:0] q[$];
   logic [3:0] m_data;
   bit         m_valid, m_rel, m_ovf, m_to;
   int         m_age;   // cycles port_valid has been high for the current nibble

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         q.delete();
         m_data = 4'h0; m_valid = 0; m_rel = 0; m_ovf = 0; m_to = 0; m_age = 0;
      end else begin
         bit take, wr_ok, to_ev;
         take  = !m_valid && !m_rel && (q.size() != 0);
         wr_ok = enableOut && ((q.size() < DEPTH) || take);
         to_ev = 0;
         if (take) begin
            m_data  = q.pop_front();
            m_valid = 1;
            m_age   = 1;
         end else if (m_valid) begin
            if (port_ack) begin
               m_valid = 0;
               m_rel   = 1;
            end else if (m_age == ACK_TIMEOUT) begin
               m_valid = 0;
               to_ev   = 1;
            end else begin
               m_age++;
            end
         end else if (m_rel && !port_ack) begin
            m_rel = 0;
         end
         if (wr_ok) q.push_back(data_bus);
         m_ovf = (enableOut && !wr_ok) || (m_ovf && !err_clr);
         m_to  = to_ev || (m_to && !err_clr);
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (reset) begin
         check("data_out",     int'(data_out),     int'(m_data));
         check("port_valid",   int'(port_valid),   int'(m_valid));
         check("fifo_level",   int'(fifo_level),   q.size());
         check("busy",         int'(busy),         int'(q.size() == DEPTH));
         check("overflow_err", int'(overflow_err), int'(m_ovf));
         check("timeout_err",  int'(timeout_err),  int'(m_to));
      end
   end

   // Record every completed transfer seen on the port.
   logic [3:0] delivered[$];
   always @(negedge clk) begin
      if (reset && port_valid && port_ack) delivered.push_back(data_out);
   end

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_deliv(input string name, input logic [3:0] exp[$]);
      check({name, "_count"}, delivered.size(), exp.size());
      for (int i = 0; i < exp.size() && i < delivered.size(); i++)
         check(name, int'(delivered[i]), int'(exp[i]));
   endtask

   initial begin
      logic [3:0] burst[$];
      // Power-on reset.
      tick(3);
      check("rst_data_out", int'(data_out), 0);
      check("rst_valid", int'(port_valid), 0);
      check("rst_level", int'(fifo_level), 0);
      reset = 1'b1;
      tick(2);

      // Single write with the peripheral acking two cycles after valid.
      delivered.delete();
      enableOut = 1'b1; data_bus = 4'hA;
      tick();
      enableOut = 1'b0;
      tick();
      check("single_valid", int'(port_valid), 1);
      check("single_data", int'(data_out), 10);
      tick();
      ack_man = 1'b1;
      tick();
      check("single_valid_drop", int'(port_valid), 0);
      ack_man = 1'b0;
      tick(3);
      check("single_hold", int'(data_out), 10);
      check_deliv("single_deliv", '{4'hA});

      // Burst 3,7,C,F with ack low, then release a prompt peripheral.
      delivered.delete();
      burst = '{4'h3, 4'h7, 4'hC, 4'hF};
      enableOut = 1'b1;
      foreach (burst[i]) begin
         data_bus = burst[i];
         tick();
      end
      enableOut = 1'b0;
      check("burst_level", int'(fifo_level), 3);
      check("burst_busy", int'(busy), 0);
      auto_ack = 1'b1;
      tick(25);
      check_deliv("burst_deliv", burst);
      auto_ack = 1'b0;
      tick(2);

      // Overflow (with clear race on the dropped write) then ack timeout.
      delivered.delete();
      enableOut = 1'b1;
      for (int v = 1; v <= 5; v++) begin
         data_bus = 4'(v);
         tick();
      end
      data_bus = 4'h6; err_clr = 1'b1;
      tick();
      check("ovf_set_wins", int'(overflow_err), 1);
      check("ovf_busy", int'(busy), 1);
      check("ovf_level", int'(fifo_level), 4);
      enableOut = 1'b0;
      tick();
      check("ovf_cleared", int'(overflow_err), 0);
      err_clr = 1'b0;
      tick(9);
      check("to_still_valid", int'(port_valid), 1);
      check("to_no_err_yet", int'(timeout_err), 0);
      tick();
      check("to_valid_drop", int'(port_valid), 0);
      check("to_err", int'(timeout_err), 1);
      check("to_data_kept", int'(data_out), 1);
      tick();
      check("to_next_valid", int'(port_valid), 1);
      check("to_next_data", int'(data_out), 2);
      check("to_next_level", int'(fifo_level), 3);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("clr_ovf", int'(overflow_err), 0);
      check("clr_to", int'(timeout_err), 0);
      auto_ack = 1'b1;
      tick(25);
      check_deliv("ovf_deliv", '{4'h2, 4'h3, 4'h4, 4'h5});
      auto_ack = 1'b0;
      tick(2);

      // Asynchronous reset in the middle of VALID with three entries queued.
      enableOut = 1'b1;
      burst = '{4'h9, 4'h8, 4'h7, 4'h6};
      foreach (burst[i]) begin
         data_bus = burst[i];
         tick();
      end
      enableOut = 1'b0;
      check("pre_rst_valid", int'(port_valid), 1);
      check("pre_rst_level", int'(fifo_level), 3);
      #2;
      reset = 1'b0;
      #1;
      check("arst_data_out", int'(data_out), 0);
      check("arst_valid", int'(port_valid), 0);
      check("arst_level", int'(fifo_level), 0);
      check("arst_ovf", int'(overflow_err), 0);
      check("arst_to", int'(timeout_err), 0);
      tick();
      reset = 1'b1;
      tick(4);
      check("post_rst_valid", int'(port_valid), 0);
      check("post_rst_level", int'(fifo_level), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
